// File: rtl/uat_tx_arb_if.sv
// Handshake bundle between requesters, the UART TX arbiter and the transmitter datapath.
// master = arbiter side, slave = requester/transmitter side.
interface uat_tx_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ack;
  logic               tx_busy;
  logic               tx_load;
  logic [DW-1:0]      tx_data;
  logic [1:0]         grant_id;
  logic               arb_busy;
  logic               err_clr;
  logic               timeout_err;

  modport master (
    input  req_valid, req_data, tx_busy, err_clr,
    output req_ack, tx_load, tx_data, grant_id, arb_busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_busy, err_clr,
    input  req_ack, tx_load, tx_data, grant_id, arb_busy, timeout_err
  );
endinterface

// File: rtl/uat_tx_arb.sv
// Round-robin arbiter sharing one UART TX among NREQ requesters; load/ack one cycle after the grant edge,
// no grant while tx_busy, requesters hold req_valid until ack. UAT_TX_ARB_PRIO0_EN: requester 0 strict priority.
module uat_tx_arb #(
  parameter int NREQ   = 4,
  parameter int DW     = 8,
  parameter int TO_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  uat_tx_arb_if.master  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

  state_t            state;
  logic [1:0]        last_grant;
  logic [1:0]        win;
  logic              found;
  logic [2:0]        idx;
  logic [7:0]        cnt;
  logic              tx_load_q;
  logic [DW-1:0]     tx_data_q;
  logic [NREQ-1:0]   ack_q;
  logic [1:0]        grant_q;
  logic              arb_busy_q;
  logic              err_q;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, last_grant} + 3'(k);
      if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
      if (!found && bus.req_valid[idx[1:0]]) begin
        win   = idx[1:0];
        found = 1'b1;
      end
    end
`ifdef UAT_TX_ARB_PRIO0_EN
    if (bus.req_valid[0]) win = 2'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 2'(NREQ - 1);
      cnt        <= '0;
      tx_load_q  <= 1'b0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      grant_q    <= '0;
      arb_busy_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_load_q <= 1'b0;
      ack_q     <= '0;
      // a timeout on the same edge overrides this clear
      if (bus.err_clr) err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.tx_busy && |bus.req_valid) begin
            tx_data_q  <= bus.req_data[DW*int'(win) +: DW];
            grant_q    <= win;
`ifdef UAT_TX_ARB_PRIO0_EN
            // priority grants to 0 leave the rotation pointer of the others untouched
            if (win != 2'd0) last_grant <= win;
`else
            last_grant <= win;
`endif
            tx_load_q  <= 1'b1;
            ack_q[win] <= 1'b1;
            arb_busy_q <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == 8'(TO_CYC - 1)) begin
            err_q      <= 1'b1;
            arb_busy_q <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            arb_busy_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_load     = tx_load_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.req_ack     = ack_q;
  assign bus.grant_id    = grant_q;
  assign bus.arb_busy    = arb_busy_q;
  assign bus.timeout_err = err_q;

endmodule

// File: doc/uat_tx_arb.md
Name: uat_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among NREQ byte requesters.
- Selects a requester, hands its byte to the transmitter with a one-cycle load pulse, then waits for the frame to start and finish.
- Sits between the command/status sources and the UART TX datapath (shift register plus start/data/stop state machine).
- Single clock domain.

Parameters:
- NREQ, 4, number of requesters. Legal range 2..4. Grant index is 2 bits.
- DW, 8, data byte width.
- TO_CYC, 16, maximum cycles to wait for tx_busy to rise after tx_load. Legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i = requester i has a byte pending. Held high until ack.
- req_data  in  NREQ*DW  flattened; requester i at [DW*i+DW-1 : DW*i].
- req_ack  out  NREQ  one-cycle pulse on the accepted requester's bit.
- tx_busy  in  1  from transmitter; high while a frame is in progress.
- tx_load  out  1  one-cycle load strobe to transmitter.
- tx_data  out  DW  registered byte to transmitter; valid while tx_load=1, held until next load.
- grant_id  out  2  index of the most recently granted requester.
- arb_busy  out  1  high in any state other than IDLE.
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky; set when tx_busy fails to rise within TO_CYC cycles.

Behaviour:
- Reset (rst=1 at a clock edge; takes priority over everything, including mid-frame):
  - state=IDLE, tx_load=0, tx_data=0, req_ack=0, grant_id=0, arb_busy=0, timeout_err=0.
  - Internal last_grant=NREQ-1, so requester 0 wins first. wait counter=0.
- States: IDLE, LOAD, WAIT_START, WAIT_DONE.
- IDLE:
  - If tx_busy=0 and any req_valid bit=1: pick winner w = first set bit searching upward from last_grant+1, modulo NREQ.
  - At that edge: tx_data<=req_data[w], grant_id<=w, last_grant<=w, go to LOAD.
  - Otherwise stay in IDLE. If tx_busy=1 in IDLE, do not grant.
- LOAD (exactly one cycle):
  - tx_load=1 and req_ack[w]=1 in this cycle only.
  - Next state WAIT_START; counter cleared to 0.
- WAIT_START:
  - If tx_busy=1: go to WAIT_DONE.
  - Else if counter=TO_CYC-1: set timeout_err=1, go to IDLE.
  - Else increment counter.
- WAIT_DONE:
  - When tx_busy=0: go to IDLE. No timeout in this state.
- Latency: req_valid rises in IDLE with tx_busy=0 at edge N → tx_load and req_ack high in cycle N+1.
  - Minimum spacing between two tx_load pulses = 1 (IDLE) + 1 (LOAD) + 1 or more (WAIT_START) + frame length.
- Requester handshake:
  - Requester must hold req_valid and req_data stable until its ack. Data is sampled at the IDLE grant edge.
  - req_valid still high in the cycle after ack is treated as a new byte.
  - Dropping req_valid before ack withdraws the request. If dropped after the grant edge, the byte already latched is still sent and acked.
- Simultaneous requests: strict rotation. A requester just served is lowest priority next round.
  - Single active requester is re-granted back-to-back.
- Error flag: err_clr=1 clears timeout_err. If set and clear occur in the same cycle, set wins.
- Only one bit of req_ack is ever high. tx_load and req_ack are high in the same cycle only.

Optional Feature:
- Macro: UAT_TX_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. If req_valid[0]=1 in IDLE it wins regardless of last_grant. Remaining requesters rotate round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters as above.

Test Plan:
- Reset then req_valid=4'b0001, req_data[7:0]=8'hA5, tx_busy=0 → one cycle later tx_load=1, tx_data=8'hA5, req_ack=4'b0001, grant_id=0.
- req_valid=4'b1111 held; model tx_busy high 10 cycles after each load → grant order 0,1,2,3,0; exactly one ack per load.
- tx_busy held 1 in IDLE with req_valid=4'b0010 → no tx_load until tx_busy=0, then load with grant_id=1.
- After load, tx_busy stays 0 for TO_CYC=16 cycles → timeout_err=1 and return to IDLE. err_clr pulse → timeout_err=0. Set and clear in the same cycle → stays 1.
- rst=1 while in WAIT_DONE → next cycle all outputs at reset values; with req_valid=4'b1000, the next grant goes to requester 3.
- With UAT_TX_ARB_PRIO0_EN, req_valid=4'b0011 held → requester 0 granted every time. Without the macro → grants alternate 0,1,0,1.
